rf_multiport: RTL and testbench

Parametrised multi-read-port register file for the CPU datapath, successor to the fixed 32x32 two-read/one-write register file. Reads and writes are fully synchronous to one clock edge. The block adds configurable width, depth and read-port count, a hardwired-zero register, and a hardware clear sequencer that zeroes every entry after reset or on request. An optional write-to-read bypass makes same-cycle writes visible to reads.

---
 rtl/rf_multiport.sv | 110 +++++++++++
 tb/tb_rf_multiport.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/rf_multiport.sv
// Multi-read-port register file with hardwired-zero r0 and a clear sequencer that zeroes the array after reset or clr.
// Optional same-cycle write-to-read bypass is enabled by defining RF_BYPASS_EN.
module rf_multiport #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    output logic                       busy
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_e;

    state_e                   state_q, state_d;
    logic [ADDR_W-1:0]        clr_cnt_q, clr_cnt_d;
    logic                     busy_q, busy_d;
    logic [NUM_RD*DATA_W-1:0] rd_data_q, rd_data_d;
    logic [DATA_W-1:0]        mem_q [DEPTH];

    logic                     mem_we;
    logic [ADDR_W-1:0]        mem_waddr;
    logic [DATA_W-1:0]        mem_wdata;
    logic                     user_we;
    logic                     rd_zero;

    // The single array write port is shared between the clear sequencer and user writes.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        busy_d    = busy_q;
        mem_we    = 1'b0;
        mem_waddr = wr_addr;
        mem_wdata = wr_data;
        user_we   = 1'b0;
        case (state_q)
            S_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_cnt_q;
                mem_wdata = '0;
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == LAST_ADDR) begin
                    state_d = S_RUN;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                if (clr) begin
                    state_d   = S_CLEAR;
                    clr_cnt_d = '0;
                    busy_d    = 1'b1;
                end else begin
                    user_we = wr_en && (wr_addr != '0);
                    mem_we  = user_we;
                end
            end
        endcase
    end

    // Reads are forced to zero while clearing and on the edge that accepts clr, so no stale data escapes.
    assign rd_zero = (state_q == S_CLEAR) || clr;

    always_comb begin
        rd_data_d = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (!rd_zero && (rd_addr[i*ADDR_W +: ADDR_W] != '0)) begin
                rd_data_d[i*DATA_W +: DATA_W] = mem_q[rd_addr[i*ADDR_W +: ADDR_W]];
`ifdef RF_BYPASS_EN
                if (user_we && (rd_addr[i*ADDR_W +: ADDR_W] == wr_addr)) begin
                    rd_data_d[i*DATA_W +: DATA_W] = wr_data;
                end
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_CLEAR;
            clr_cnt_q <= '0;
            busy_q    <= 1'b1;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            busy_q    <= busy_d;
            rd_data_q <= rd_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign rd_data = rd_data_q;
    assign busy    = busy_q;
endmodule

// File: tb/tb_rf_multiport.sv
// Directed bench for rf_multiport: clear sequencing, r0 behaviour, same-cycle write/read, clr and rst during clear.
// Expected read data is queued when a read is issued and compared one edge later.
module tb_rf_multiport;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NUM_RD = 2;
    localparam int DEPTH  = 32;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     clr;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic                     busy;

    logic [DATA_W-1:0] exp_q[$];
    logic              rd_pending = 1'b0;
    int                n_cmp = 0;
    int                n_err = 0;
    string             cur_tag = "init";
    logic [DATA_W-1:0] shadow [8];
    logic [DATA_W-1:0] same_cycle_exp;

    rf_multiport #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .NUM_RD(NUM_RD)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .wr_en  (wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then compare any reads that were issued before it.
    task automatic tick();
        @(posedge clk);
        #1;
        if (rd_pending) begin
            for (int i = 0; i < NUM_RD; i++) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $error("FAIL %s/sb_empty: observed empty queue expected entry", cur_tag);
                end else begin
                    check($sformatf("%s/rd%0d", cur_tag, i), rd_data[i*DATA_W +: DATA_W], exp_q.pop_front());
                end
            end
            rd_pending = 1'b0;
        end
    endtask

    task automatic rd(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1,
                      input logic [DATA_W-1:0] e0, input logic [DATA_W-1:0] e1);
        rd_addr = {a1, a0};
        exp_q.push_back(e0);
        exp_q.push_back(e1);
        rd_pending = 1'b1;
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
    endtask

    // Runs n clear-sequence edges with random reads (expected 0) and writes (expected ignored).
    task automatic run_clear(input string tag, input int n, input int clr_at);
        for (int k = 1; k <= n; k++) begin
            cur_tag = $sformatf("%s_c%0d", tag, k);
            clr = (k == clr_at);
            rd(ADDR_W'($urandom_range(1, 31)), ADDR_W'($urandom_range(0, 31)), '0, '0);
            wr(ADDR_W'($urandom_range(1, 31)), $urandom);
            tick();
            check({cur_tag, "/busy"}, 32'(busy), 32'(k < DEPTH));
        end
        clr   = 1'b0;
        wr_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;

        // Reset state
        cur_tag = "reset";
        tick();
        tick();
        check("reset/busy", 32'(busy), 32'd1);
        check("reset/rd0", rd_data[0 +: DATA_W], '0);
        check("reset/rd1", rd_data[DATA_W +: DATA_W], '0);

        // Initial clear: busy exactly DEPTH edges after release
        rst = 1'b0;
        run_clear("init", DEPTH, 0);

        cur_tag = "scan";
        for (int a = 0; a < DEPTH; a++) begin
            rd(ADDR_W'(a), ADDR_W'(DEPTH - 1 - a), '0, '0);
            tick();
        end

        // Write r5 then read it on both ports
        cur_tag = "w_r5";
        wr(5'd5, 32'hDEADBEEF);
        tick();
        wr_en = 1'b0;
        rd(5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF);
        tick();

        // r0 is never stored, even with a same-cycle read
        cur_tag = "w_r0";
        wr(5'd0, 32'h12345678);
        rd(5'd0, 5'd5, '0, 32'hDEADBEEF);
        tick();
        wr_en = 1'b0;
        rd(5'd0, 5'd0, '0, '0);
        tick();

        // Same-cycle write/read of r7
        cur_tag = "w_r7_init";
        wr(5'd7, 32'h00000001);
        tick();
`ifdef RF_BYPASS_EN
        same_cycle_exp = 32'hA5A5A5A5;
`else
        same_cycle_exp = 32'h00000001;
`endif
        cur_tag = "same_cycle_r7";
        wr(5'd7, 32'hA5A5A5A5);
        rd(5'd7, 5'd5, same_cycle_exp, 32'hDEADBEEF);
        tick();
        wr_en = 1'b0;
        cur_tag = "after_r7";
        rd(5'd7, 5'd7, 32'hA5A5A5A5, 32'hA5A5A5A5);
        tick();

        // Random data into r8..r15, read back in crossed pairs
        cur_tag = "rand_w";
        for (int i = 0; i < 8; i++) begin
            shadow[i] = $urandom;
            wr(ADDR_W'(8 + i), shadow[i]);
            tick();
        end
        wr_en = 1'b0;
        cur_tag = "rand_r";
        for (int i = 0; i < 8; i++) begin
            rd(ADDR_W'(8 + i), ADDR_W'(15 - i), shadow[i], shadow[7 - i]);
            tick();
        end

        // clr accepted together with a write to r4; clr again mid-sequence is ignored
        cur_tag = "w_r3";
        wr(5'd3, 32'h00000055);
        tick();
        cur_tag = "clr_accept";
        clr = 1'b1;
        wr(5'd4, 32'h00000099);
        rd(5'd3, 5'd5, '0, '0);
        tick();
        clr = 1'b0;
        wr_en = 1'b0;
        check("clr_accept/busy", 32'(busy), 32'd1);
        run_clear("clr", DEPTH, 5);
        cur_tag = "post_clr";
        rd(5'd3, 5'd4, '0, '0);
        tick();
        rd(5'd5, 5'd7, '0, '0);
        tick();

        // rst in the middle of a clear restarts the sequence
        cur_tag = "w_r9";
        wr(5'd9, 32'h00000009);
        tick();
        wr_en = 1'b0;
        rd(5'd9, 5'd9, 32'h00000009, 32'h00000009);
        tick();
        cur_tag = "clr2_accept";
        clr = 1'b1;
        tick();
        clr = 1'b0;
        run_clear("clr2", 10, 0);
        cur_tag = "mid_rst";
        rst = 1'b1;
        rd(5'd9, 5'd1, '0, '0);
        tick();
        tick();
        check("mid_rst/busy", 32'(busy), 32'd1);
        rst = 1'b0;
        run_clear("rst2", DEPTH, 0);

        cur_tag = "final";
        wr(5'd31, 32'hCAFEF00D);
        rd(5'd9, 5'd1, '0, '0);
        tick();
        wr_en = 1'b0;
        rd(5'd31, 5'd9, 32'hCAFEF00D, '0);
        tick();

        check("final/queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
